// File: rtl/cmult_pkg.sv
// Shared widths and the tag record for the complex-multiplier share arbiter.
// Tag ids are sized for the largest supported requester count (8).
package cmult_pkg;

  localparam int CMULT_A_W      = 16;
  localparam int CMULT_B_W      = 18;
  localparam int CMULT_P_W      = 35;
  localparam int CMULT_ID_W_MAX = 3;

  typedef struct packed {
    logic                      valid;
    logic [CMULT_ID_W_MAX-1:0] id;
  } cmult_tag_t;

endpackage

// File: rtl/cmult_share_arbiter_if.sv
// Request, multiplier and response signals of the share arbiter.
// Handshake: a request transfers on a rising edge where req_valid[i] && req_ready[i];
// valid may drop without a grant, and responses carry no ready (they must be taken).
interface cmult_share_arbiter_if
  import cmult_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*CMULT_A_W-1:0] req_real_a;
  logic [NUM_REQ*CMULT_A_W-1:0] req_imag_a;
  logic [NUM_REQ*CMULT_B_W-1:0] req_real_b;
  logic [NUM_REQ*CMULT_B_W-1:0] req_imag_b;

  logic [CMULT_A_W-1:0]         mul_real_a;
  logic [CMULT_A_W-1:0]         mul_imag_a;
  logic [CMULT_B_W-1:0]         mul_real_b;
  logic [CMULT_B_W-1:0]         mul_imag_b;
  logic [CMULT_P_W-1:0]         mul_real_out;
  logic [CMULT_P_W-1:0]         mul_imag_out;

  logic                         rsp_valid;
  logic [ID_W-1:0]              rsp_id;
  logic [CMULT_P_W-1:0]         rsp_real;
  logic [CMULT_P_W-1:0]         rsp_imag;

  modport slave (
    input  req_valid, req_real_a, req_imag_a, req_real_b, req_imag_b,
    input  mul_real_out, mul_imag_out,
    output req_ready,
    output mul_real_a, mul_imag_a, mul_real_b, mul_imag_b,
    output rsp_valid, rsp_id, rsp_real, rsp_imag
  );

  modport master (
    output req_valid, req_real_a, req_imag_a, req_real_b, req_imag_b,
    output mul_real_out, mul_imag_out,
    input  req_ready,
    input  mul_real_a, mul_imag_a, mul_real_b, mul_imag_b,
    input  rsp_valid, rsp_id, rsp_real, rsp_imag
  );

endinterface

// File: rtl/cmult_rr_arbiter.sv
// Generic round-robin arbiter: search starts at ptr and wraps upward; the
// pointer moves just past each winner and holds when nothing is granted.
module cmult_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  logic [IW-1:0] ptr_q, ptr_d;
  int            cand;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    grant     = '0;
    cand      = 0;
    ptr_d     = ptr_q;
    // No grants while in reset so requesters never see ready during it.
    if (!rst) begin
      for (int off = 0; off < N; off++) begin
        cand = int'(ptr_q) + off;
        if (cand >= N) cand = cand - N;
        if (!grant_any && req[cand[IW-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = cand[IW-1:0];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      grant[i] = grant_any && (grant_idx == IW'(i));
    end
    if (grant_any) begin
      ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cmult_share_arbiter.sv
// Time-shares one pipelined complex multiplier between NUM_REQ requesters and tags
// each product with its owner. Optional per-requester grant counters: CMULT_ARB_STATS_EN.
module cmult_share_arbiter
  import cmult_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  cmult_share_arbiter_if.slave      bus
`ifdef CMULT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_count
`endif
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int STAGES = MULT_LATENCY + 1;

  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;

  cmult_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign bus.req_ready = grant;

  logic [CMULT_A_W-1:0] mul_real_a_q, mul_real_a_d;
  logic [CMULT_A_W-1:0] mul_imag_a_q, mul_imag_a_d;
  logic [CMULT_B_W-1:0] mul_real_b_q, mul_real_b_d;
  logic [CMULT_B_W-1:0] mul_imag_b_q, mul_imag_b_d;

  // One-hot grant selects the operands; idle cycles feed zeros to the multiplier.
  always_comb begin
    mul_real_a_d = '0;
    mul_imag_a_d = '0;
    mul_real_b_d = '0;
    mul_imag_b_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mul_real_a_d = bus.req_real_a[i*CMULT_A_W +: CMULT_A_W];
        mul_imag_a_d = bus.req_imag_a[i*CMULT_A_W +: CMULT_A_W];
        mul_real_b_d = bus.req_real_b[i*CMULT_B_W +: CMULT_B_W];
        mul_imag_b_d = bus.req_imag_b[i*CMULT_B_W +: CMULT_B_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_real_a_q <= '0;
      mul_imag_a_q <= '0;
      mul_real_b_q <= '0;
      mul_imag_b_q <= '0;
    end else begin
      mul_real_a_q <= mul_real_a_d;
      mul_imag_a_q <= mul_imag_a_d;
      mul_real_b_q <= mul_real_b_d;
      mul_imag_b_q <= mul_imag_b_d;
    end
  end

  assign bus.mul_real_a = mul_real_a_q;
  assign bus.mul_imag_a = mul_imag_a_q;
  assign bus.mul_real_b = mul_real_b_q;
  assign bus.mul_imag_b = mul_imag_b_q;

  cmult_tag_t tag_q [STAGES];
  cmult_tag_t tag_d [STAGES];

  // Stage 0 loads with the operand registers; the last stage lines up with the product.
  always_comb begin
    tag_d[0].valid = grant_any;
    tag_d[0].id    = CMULT_ID_W_MAX'(grant_idx);
    for (int s = 1; s < STAGES; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < STAGES; s++) begin
      if (rst) tag_q[s] <= '0;
      else     tag_q[s] <= tag_d[s];
    end
  end

  logic unused_tag_bits;
  assign unused_tag_bits = ^tag_q[STAGES-1].id;

  assign bus.rsp_valid = tag_q[STAGES-1].valid;
  assign bus.rsp_id    = tag_q[STAGES-1].id[ID_W-1:0];
  assign bus.rsp_real  = tag_q[STAGES-1].valid ? bus.mul_real_out : '0;
  assign bus.rsp_imag  = tag_q[STAGES-1].valid ? bus.mul_imag_out : '0;

`ifdef CMULT_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (grant[i] && (cnt_q[i] != 16'hFFFF)) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) cnt_q[i] <= '0;
      else     cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_count[i*16 +: 16] = cnt_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_cmult_share_arbiter.sv
// Bench for cmult_share_arbiter: multiplier model, negedge scoreboard, scenario tasks.
// Build with CMULT_ARB_STATS_EN defined to also exercise the grant counters.
module tb_cmult_share_arbiter;
  import cmult_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int MULT_LATENCY = 3;
  localparam int ID_W         = 2;
  localparam int EW           = ID_W + 2 * CMULT_P_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmult_share_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

`ifdef CMULT_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_count;
`endif

  cmult_share_arbiter #(.NUM_REQ(NUM_REQ), .MULT_LATENCY(MULT_LATENCY)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef CMULT_ARB_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  function automatic logic [2*CMULT_P_W-1:0] cmul(input logic [15:0] ar, input logic [15:0] ai,
                                                  input logic [17:0] br, input logic [17:0] bi);
    longint sar, sai, sbr, sbi, re, im;
    logic [CMULT_P_W-1:0] re_t, im_t;
    sar = longint'($signed(ar));
    sai = longint'($signed(ai));
    sbr = longint'($signed(br));
    sbi = longint'($signed(bi));
    re = sar * sbr - sai * sbi;
    im = sar * sbi + sai * sbr;
    re_t = re[CMULT_P_W-1:0];
    im_t = im[CMULT_P_W-1:0];
    return {re_t, im_t};
  endfunction

  // External multiplier: MULT_LATENCY register stages after the operand registers.
  logic [CMULT_P_W-1:0] p_re [MULT_LATENCY];
  logic [CMULT_P_W-1:0] p_im [MULT_LATENCY];
  always @(posedge clk) begin
    logic [2*CMULT_P_W-1:0] p;
    p = cmul(bus.mul_real_a, bus.mul_imag_a, bus.mul_real_b, bus.mul_imag_b);
    p_re[0] <= p[2*CMULT_P_W-1:CMULT_P_W];
    p_im[0] <= p[CMULT_P_W-1:0];
    for (int k = 1; k < MULT_LATENCY; k++) begin
      p_re[k] <= p_re[k-1];
      p_im[k] <= p_im[k-1];
    end
  end
  assign bus.mul_real_out = p_re[MULT_LATENCY-1];
  assign bus.mul_imag_out = p_im[MULT_LATENCY-1];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state
  logic [EW-1:0] exp_q [$];
  int            due_q [$];
  int            model_ptr = 0;
  logic          rst_prev  = 1'b1;
  logic          hs_prev   = 1'b0;
  logic [15:0]   prev_ar, prev_ai;
  logic [17:0]   prev_br, prev_bi;
  int            model_cnt [NUM_REQ];
  int            mon_g;
  logic [NUM_REQ-1:0] exp_ready;
  logic [EW-1:0] head;
  logic [2*CMULT_P_W-1:0] prod;
  logic [68:0]   exp_mul;

  initial for (int i = 0; i < NUM_REQ; i++) model_cnt[i] = 0;

  always @(negedge clk) begin
    if (rst_prev) begin
      exp_q.delete();
      due_q.delete();
      model_ptr = 0;
      hs_prev   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) model_cnt[i] = 0;
    end
    exp_mul = hs_prev ? {prev_ar, prev_ai, prev_br, prev_bi} : '0;
    total++;
    if ({bus.mul_real_a, bus.mul_imag_a, bus.mul_real_b, bus.mul_imag_b} !== exp_mul) begin
      bad++;
      $display("FAIL mul_operands cyc=%0d got=%h exp=%h", cyc,
               {bus.mul_real_a, bus.mul_imag_a, bus.mul_real_b, bus.mul_imag_b}, exp_mul);
    end
    if (bus.rsp_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_unexpected cyc=%0d id=%0d", cyc, bus.rsp_id);
      end else begin
        head = exp_q.pop_front();
        if ({bus.rsp_id, bus.rsp_real, bus.rsp_imag} !== head || due_q[0] != cyc) begin
          bad++;
          $display("FAIL rsp_data cyc=%0d got id=%0d re=%h im=%h exp id=%0d re=%h im=%h due=%0d",
                   cyc, bus.rsp_id, bus.rsp_real, bus.rsp_imag, head[EW-1 -: ID_W],
                   head[2*CMULT_P_W-1:CMULT_P_W], head[CMULT_P_W-1:0], due_q[0]);
        end
        void'(due_q.pop_front());
      end
    end else begin
      total++;
      if (bus.rsp_valid !== 1'b0 || bus.rsp_real !== '0 || bus.rsp_imag !== '0) begin
        bad++;
        $display("FAIL rsp_idle cyc=%0d valid=%b re=%h im=%h exp 0", cyc, bus.rsp_valid,
                 bus.rsp_real, bus.rsp_imag);
      end
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        bad++;
        $display("FAIL rsp_missing cyc=%0d due=%0d", cyc, due_q[0]);
        void'(due_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
    exp_ready = '0;
    mon_g = -1;
    if (!rst) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (mon_g < 0 && bus.req_valid[(model_ptr + off) % NUM_REQ]) mon_g = (model_ptr + off) % NUM_REQ;
      end
    end
    if (mon_g >= 0) exp_ready[mon_g] = 1'b1;
    total++;
    if (bus.req_ready !== exp_ready) begin
      bad++;
      $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_ready);
    end
    hs_prev = (mon_g >= 0);
    if (mon_g >= 0) begin
      prev_ar = bus.req_real_a[mon_g*16 +: 16];
      prev_ai = bus.req_imag_a[mon_g*16 +: 16];
      prev_br = bus.req_real_b[mon_g*18 +: 18];
      prev_bi = bus.req_imag_b[mon_g*18 +: 18];
      prod = cmul(prev_ar, prev_ai, prev_br, prev_bi);
      exp_q.push_back({ID_W'(mon_g), prod});
      due_q.push_back(cyc + 1 + MULT_LATENCY);
      model_ptr = (mon_g + 1) % NUM_REQ;
      if (model_cnt[mon_g] < 65535) model_cnt[mon_g]++;
    end
    rst_prev = rst;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_real_a[i*16 +: 16] = 16'($urandom);
      bus.req_imag_a[i*16 +: 16] = 16'($urandom);
      bus.req_real_b[i*18 +: 18] = 18'($urandom);
      bus.req_imag_b[i*18 +: 18] = 18'($urandom);
    end
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick();
    rst = 1'b1;
    bus.req_valid = '1;
    rand_ops();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (bus.req_ready !== '0 || bus.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs ready=%b rsp_valid=%b exp 0", bus.req_ready, bus.rsp_valid);
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_grant got=%b exp=0001", bus.req_ready);
    end
    tick();
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    int hs_cyc;
    bit seen;
    do_reset();
    rand_ops();
    bus.req_real_a[47:32] = 16'h0003;
    bus.req_imag_a[47:32] = 16'h0002;
    bus.req_real_b[53:36] = 18'h00005;
    bus.req_imag_b[53:36] = 18'h00004;
    bus.req_valid = 4'b0100;
    @(negedge clk);
    hs_cyc = cyc;
    tick();
    bus.req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        seen = 1'b1;
        total++;
        if (bus.rsp_id !== 2'd2 || bus.rsp_real !== 35'd7 || bus.rsp_imag !== 35'd22 ||
            cyc != hs_cyc + 4) begin
          bad++;
          $display("FAIL single_rsp id=%0d re=%0d im=%0d lat=%0d exp id=2 re=7 im=22 lat=4",
                   bus.rsp_id, bus.rsp_real, bus.rsp_imag, cyc - hs_cyc);
        end
      end
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL single_timeout no response within 10 cycles exp 1");
    end
  endtask

  task automatic test_all_valid();
    int ids [$];
    do_reset();
    bus.req_valid = '1;
    rand_ops();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 8) begin
        total++;
        if (bus.req_ready !== 4'(1 << (i % 4))) begin
          bad++;
          $display("FAIL all_valid_grant step=%0d got=%b exp=%b", i, bus.req_ready, 4'(1 << (i % 4)));
        end
      end
      if (bus.rsp_valid === 1'b1) ids.push_back(int'(bus.rsp_id));
      tick();
      if (i >= 7) bus.req_valid = '0;
      else        rand_ops();
    end
    total++;
    if (ids.size() != 8) begin
      bad++;
      $display("FAIL all_valid_rsp_count got=%0d exp=8", ids.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        total++;
        if (ids[i] != i % 4) begin
          bad++;
          $display("FAIL all_valid_rsp_id idx=%0d got=%0d exp=%0d", i, ids[i], i % 4);
        end
      end
    end
  endtask

  task automatic test_two_req();
    logic [3:0] exp_g [3];
    exp_g[0] = 4'b1000;
    exp_g[1] = 4'b0010;
    exp_g[2] = 4'b1000;
    do_reset();
    rand_ops();
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      @(negedge clk);
      total++;
      if (bus.req_ready !== exp_g[i]) begin
        bad++;
        $display("FAIL two_req_grant step=%0d got=%b exp=%b", i, bus.req_ready, exp_g[i]);
      end
      tick();
    end
    bus.req_valid = '0;
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if ({bus.mul_real_a, bus.mul_imag_a, bus.mul_real_b, bus.mul_imag_b} !== 68'd0) begin
        bad++;
        $display("FAIL idle_mul_zero step=%0d got=%h exp 0", i,
                 {bus.mul_real_a, bus.mul_imag_a, bus.mul_real_b, bus.mul_imag_b});
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int hs_cyc;
    int seen_cyc;
    do_reset();
    rand_ops();
    bus.req_valid = 4'b0001;
    repeat (3) tick();
    rst = 1'b1;
    bus.req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid_stale step=%0d rsp_valid=%b exp 0", i, bus.rsp_valid);
      end
      tick();
    end
    rand_ops();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    hs_cyc = cyc;
    tick();
    bus.req_valid = '0;
    seen_cyc = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1 && seen_cyc < 0) seen_cyc = cyc;
    end
    total++;
    if (seen_cyc != hs_cyc + 4) begin
      bad++;
      $display("FAIL reset_mid_latency got=%0d exp=4", seen_cyc < 0 ? -1 : seen_cyc - hs_cyc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      bus.req_valid = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      tick();
    end
    bus.req_valid = '0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_drain outstanding=%0d exp=0", exp_q.size());
    end
  endtask

`ifdef CMULT_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      rand_ops();
      bus.req_valid = 4'($urandom_range(0, 15));
      tick();
    end
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      total++;
      if (grant_count[i*16 +: 16] !== 16'(model_cnt[i])) begin
        bad++;
        $display("FAIL stats_count req=%0d got=%0d exp=%0d", i, grant_count[i*16 +: 16], model_cnt[i]);
      end
    end
    tick();
    bus.req_valid = 4'b0001;
    repeat (70000) tick();
    bus.req_valid = '0;
    tick();
    @(negedge clk);
    total++;
    if (grant_count[15:0] !== 16'hFFFF) begin
      bad++;
      $display("FAIL stats_saturate got=%h exp=ffff", grant_count[15:0]);
    end
    for (int i = 1; i < NUM_REQ; i++) begin
      total++;
      if (grant_count[i*16 +: 16] !== 16'(model_cnt[i])) begin
        bad++;
        $display("FAIL stats_other req=%0d got=%0d exp=%0d", i, grant_count[i*16 +: 16], model_cnt[i]);
      end
    end
    tick();
  endtask
`endif

  initial begin
    bus.req_valid  = '0;
    bus.req_real_a = '0;
    bus.req_imag_a = '0;
    bus.req_real_b = '0;
    bus.req_imag_b = '0;
    test_reset();
    test_single();
    test_all_valid();
    test_two_req();
    test_reset_mid();
    test_random();
`ifdef CMULT_ARB_STATS_EN
    test_stats();
`endif
    repeat (8) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
